// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a contiguous, wrapping run of addresses on a
// synchronous ROM. Each returned word is captured into a single-entry
// valid/ready output, so the consumer drains the ROM at its own pace.
module rom_stream_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1   // ROM read latency, 1..3 edges
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_count,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  // Two bits cover the whole legal latency range.
  localparam int LAT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [ADDR_W-1:0]   r_rom_addr,  w_rom_addr_nxt;
  logic [DATA_W-1:0]   r_out_data,  w_out_data_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;
  logic [ADDR_W:0]     r_remaining, w_remaining_nxt;
  logic [LAT_W-1:0]    r_lat_cnt,   w_lat_cnt_nxt;

  logic                w_lat_hit;
  logic                w_last_word;

  assign w_lat_hit   = (r_lat_cnt == LAT_W'(RD_LAT));
  assign w_last_word = (r_remaining == (ADDR_W+1)'(1));

  // Next-state and next-datapath decode; everything holds unless a state acts.
  always_comb begin
    w_state_nxt     = r_state;
    w_rom_addr_nxt  = r_rom_addr;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_remaining_nxt = r_remaining;
    w_lat_cnt_nxt   = r_lat_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_count != '0) begin
            w_rom_addr_nxt  = i_base_addr;
            w_remaining_nxt = i_count;
            w_busy_nxt      = 1'b1;
            w_lat_cnt_nxt   = '0;
            w_state_nxt     = S_WAIT;
          end else begin
            // Empty run: complete immediately without ever going busy.
            w_done_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Address is stable; wait out the ROM pipeline, then capture.
        if (w_lat_hit) begin
          w_out_data_nxt  = i_rom_data;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end
      S_HOLD: begin
        if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_remaining_nxt = r_remaining - (ADDR_W+1)'(1);
          if (w_last_word) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            // Natural ADDR_W-bit overflow gives the wrap to address 0.
            w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
            w_lat_cnt_nxt  = '0;
            w_state_nxt    = S_WAIT;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath and status registers; reset discards any in-flight word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rom_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_lat_cnt   <= '0;
    end else begin
      r_rom_addr  <= w_rom_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_remaining <= w_remaining_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
Sequencer that sits directly upstream of the synchronous lookup ROM. On a start command it issues a contiguous run of ROM addresses from a base address, with wrap-around. It captures each returned word and presents it on a single-entry valid/ready output stream, so a downstream consumer can drain ROM contents at its own pace.

Parameters:
ADDR_W, 3, ROM address width; the ROM has 2^ADDR_W words.
DATA_W, 8, ROM data width.
RD_LAT, 1, ROM read latency in clock edges from an address change to valid rom_data; legal range 1..3.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle command strobe, sampled only in IDLE.
base_addr  in  ADDR_W  first ROM address of the run.
count  in  ADDR_W+1  number of words to read, 0..2^ADDR_W.
rom_addr  out  ADDR_W  address to ROM; registered.
rom_data  in  DATA_W  data returned by ROM.
out_data  out  DATA_W  captured word; registered.
out_valid  out  1  out_data holds a word.
out_ready  in  1  consumer accepts the word when high together with out_valid.
busy  out  1  high from accepted start until run completes.
done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset (async, rst=1): state=IDLE; rom_addr=0, out_data=0, out_valid=0, busy=0, done=0; remaining counter=0, latency counter=0. Asserting reset mid-run aborts the run. In-flight data is discarded, and no done pulse is produced.
- States: IDLE, WAIT, HOLD.
- IDLE: start=1 and count!=0 at edge E0 -> rom_addr<=base_addr, remaining<=count, busy<=1, lat_cnt<=0, go to WAIT.
- IDLE: start=1 and count=0 -> done pulses high for the single cycle after E0. busy stays 0 and out_valid stays 0.
- start while busy: ignored. base_addr and count are not re-sampled.
- WAIT: rom_addr held stable. lat_cnt increments each edge. On the edge where lat_cnt==RD_LAT: out_data<=rom_data, out_valid<=1, go to HOLD. out_valid therefore rises after edge E0+RD_LAT+1.
- HOLD: out_valid=1. While out_ready=0, out_data and out_valid are held unchanged.
- HOLD with out_ready=1 at edge Ek (handshake):
  - out_valid<=0 and remaining<=remaining-1.
  - If remaining==1 at Ek: go to IDLE, busy<=0, done=1 for the cycle after Ek.
  - Otherwise: rom_addr<=rom_addr+1 modulo 2^ADDR_W (for ADDR_W=3, 7 wraps to 0), lat_cnt<=0, go to WAIT. The next out_valid rises after Ek+RD_LAT+1.
- Throughput: at most one word per RD_LAT+2 cycles. No back-to-back valid.
- count=2^ADDR_W reads every word exactly once, starting at base_addr and wrapping.
- done is never asserted together with out_valid.
- A start sampled in the cycle done is high is legal, because state is already IDLE. It begins a new run normally.
- out_ready with out_valid=0 has no effect.

Test Plan:
- Bench ROM mem[i]=8'hA0+i. Reset, then start with base=0, count=4, out_ready=1 always, RD_LAT=1 -> out_data sequence A0,A1,A2,A3. Each out_valid pulse lasts one cycle and pulses are 3 cycles apart. First valid appears 2 edges after start. done pulses once after the 4th handshake; busy falls on the same edge.
- Wrap: base=6, count=4 -> rom_addr 6,7,0,1 and out_data A6,A7,A0,A1.
- Backpressure: base=2, count=2, out_ready low for 5 cycles after first valid -> out_data=A2 held stable with out_valid=1 throughout. After ready rises, the next word is A3, then done.
- Edge counts:
  - count=0 -> single done pulse, no out_valid, busy=0.
  - count=8 from base=5 -> all eight words A5..A4 in wrap order.
  - start pulsed mid-run -> ignored, and the run completes unchanged.
- Async reset asserted while in HOLD (between clock edges) -> out_valid, busy, rom_addr and out_data go to 0 immediately without a clock edge, and no done pulse. A new start after release reads correctly from its base.
- RD_LAT=3 build: base=1, count=2 -> first valid 4 edges after start and holds A1; second word A2 valid 4 edges after the first handshake.
